// File: rtl/ppu_oam_scan.sv
// OAM scan engine for the PPU mode-2 phase: walks every OAM entry at two cycles
// per entry and keeps the first MAX_SPRITES sprites that cover the current line.
//
// state | meaning
// IDLE  | waiting for start; buffer and count hold the last result
// SCAN  | stepping k = 0 .. 2*NUM_ENTRIES-1, one OAM byte read per step
// DONE  | one-cycle completion pulse; start here launches a new scan
module ppu_oam_scan #(
    parameter int          NUM_ENTRIES = 40,
    parameter int          MAX_SPRITES = 10,
    parameter logic [15:0] OAM_BASE    = 16'hFE00,
    localparam int         CW = $clog2(MAX_SPRITES + 1),
    localparam int         IW = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    LY,
    input  logic          tall,
    output logic          OAM_RD,
    output logic [15:0]   OAM_ADDR,
    input  logic [7:0]    OAM_DATA_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic          overflow,
    input  logic [IW-1:0] rd_idx,
    output logic [7:0]    rd_y,
    output logic [7:0]    rd_x,
    output logic [7:0]    rd_offset
);

    localparam int            KW     = (NUM_ENTRIES > 1) ? $clog2(2 * NUM_ENTRIES) : 2;
    localparam logic [KW-1:0] LAST_K = KW'(2 * NUM_ENTRIES - 1);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_SPRITES);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t        state, state_nx;
    logic [KW-1:0] k;
    logic [7:0]    ly_q;
    logic          tall_q;
    logic [7:0]    y_q;
    logic          hit_q;
    logic          accept;
    logic          store;

    logic [7:0] buf_y   [MAX_SPRITES];
    logic [7:0] buf_x   [MAX_SPRITES];
    logic [7:0] buf_off [MAX_SPRITES];

    logic [8:0] line9, y9, h9;
    logic       hit_now;

    assign accept = start && (state != S_SCAN);

    // 9-bit compare so Y values near 255 cannot wrap into a false hit
    assign line9   = {1'b0, ly_q} + 9'd16;
    assign y9      = {1'b0, OAM_DATA_in};
    assign h9      = tall_q ? 9'd16 : 9'd8;
    assign hit_now = (line9 >= y9) && (line9 < (y9 + h9));

    assign store = (state == S_SCAN) && k[0] && hit_q && (count < MAX_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_SCAN;
            S_SCAN:  if (k == LAST_K) state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_SCAN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        OAM_RD   = 1'b0;
        OAM_ADDR = OAM_BASE;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_SCAN: begin
                OAM_RD   = 1'b1;
                OAM_ADDR = OAM_BASE + 16'({k[KW-1:1], 1'b0, k[0]});
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Even steps return the Y byte, odd steps the X byte of the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            ly_q     <= '0;
            tall_q   <= 1'b0;
            y_q      <= '0;
            hit_q    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            k        <= '0;
            ly_q     <= LY;
            tall_q   <= tall;
            hit_q    <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (state == S_SCAN) begin
            k <= k + KW'(1);
            if (!k[0]) begin
                y_q   <= OAM_DATA_in;
                hit_q <= hit_now;
            end else if (hit_q) begin
                if (count < MAX_C) begin
                    count <= count + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // Buffer needs no reset: reads beyond count are forced to zero.
    always_ff @(posedge clk) begin
        if (store) begin
            buf_y[count]   <= y_q;
            buf_x[count]   <= OAM_DATA_in;
            buf_off[count] <= 8'({k[KW-1:1], 2'b00});
        end
    end

    always_comb begin
        rd_y      = 8'h00;
        rd_x      = 8'h00;
        rd_offset = 8'h00;
        if ((int'(rd_idx) < int'(count)) && (int'(rd_idx) < MAX_SPRITES)) begin
            rd_y      = buf_y[rd_idx];
            rd_x      = buf_x[rd_idx];
            rd_offset = buf_off[rd_idx];
        end
    end

endmodule

// File: tb/tb_ppu_oam_scan.sv
// Directed bench for ppu_oam_scan: a behavioural OAM answers reads and a
// scoreboard of expected scan results is compared when each scan completes.
`timescale 1ns/1ps
module tb_ppu_oam_scan;

    localparam int N   = 40;
    localparam int MAX = 10;
    localparam int CW  = 4;
    localparam int IW  = 4;

    typedef struct packed {
        logic [CW-1:0]      cnt;
        logic               ovf;
        logic [MAX*24-1:0]  slots;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    LY = 8'h00;
    logic          tall = 1'b0;
    logic          OAM_RD;
    logic [15:0]   OAM_ADDR;
    logic [7:0]    OAM_DATA_in;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;
    logic [IW-1:0] rd_idx = '0;
    logic [7:0]    rd_y;
    logic [7:0]    rd_x;
    logic [7:0]    rd_offset;

    logic [7:0]    oam [0:4*N-1];
    logic [15:0]   oidx;
    exp_t          exp_q[$];
    int            n_chk  = 0;
    int            n_pass = 0;

    ppu_oam_scan #(.NUM_ENTRIES(N), .MAX_SPRITES(MAX), .OAM_BASE(16'hFE00)) dut (
        .clk(clk), .rst(rst), .start(start), .LY(LY), .tall(tall),
        .OAM_RD(OAM_RD), .OAM_ADDR(OAM_ADDR), .OAM_DATA_in(OAM_DATA_in),
        .busy(busy), .done(done), .count(count), .overflow(overflow),
        .rd_idx(rd_idx), .rd_y(rd_y), .rd_x(rd_x), .rd_offset(rd_offset)
    );

    always #5 clk = ~clk;

    assign oidx        = OAM_ADDR - 16'hFE00;
    assign OAM_DATA_in = (OAM_RD && (oidx < 16'(4*N))) ? oam[oidx[7:0]] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 4*N; i++) oam[i] = 8'h00;
    endtask

    function automatic exp_t model(input logic [7:0] ly, input logic t);
        exp_t r;
        int   line, h, y, c;
        r    = '0;
        c    = 0;
        line = int'(ly) + 16;
        h    = t ? 16 : 8;
        for (int e = 0; e < N; e++) begin
            y = int'(oam[4*e]);
            if (line >= y && line < y + h) begin
                if (c < MAX) begin
                    r.slots[c*24 +: 24] = {oam[4*e], oam[4*e+1], 8'(4*e)};
                    c++;
                end else begin
                    r.ovf = 1'b1;
                end
            end
        end
        r.cnt = CW'(c);
        return r;
    endfunction

    // Called at posedge+1 outside SCAN; returns in the first scan cycle (E0).
    task automatic start_scan(input logic [7:0] ly, input logic t, input bit hold);
        exp_q.push_back(model(ly, t));
        LY    = ly;
        tall  = t;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input bit chk_addr, input bit hold);
        int cyc;
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            if (chk_addr && cyc < 2*N) begin
                chk("oam_addr", OAM_ADDR, 32'(16'hFE00 + 16'(4*(cyc/2) + cyc%2)));
                chk("oam_rd", OAM_RD, 1);
            end
            if (hold && cyc == 2*N-1) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", cyc, 2*N);
        chk("busy_in_done", busy, 0);
    endtask

    task automatic check_result();
        exp_t        e;
        logic [23:0] s;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk("count", count, e.cnt);
        chk("overflow", overflow, e.ovf);
        for (int i = 0; i < (1 << IW); i++) begin
            rd_idx = IW'(i);
            #1;
            if (i < MAX) s = e.slots[i*24 +: 24];
            else         s = 24'h0;
            chk($sformatf("slot%0d_y", i), rd_y, s[23:16]);
            chk($sformatf("slot%0d_x", i), rd_x, s[15:8]);
            chk($sformatf("slot%0d_off", i), rd_offset, s[7:0]);
        end
        rd_idx = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        clear_oam();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_oam_rd", OAM_RD, 0);
        chk("rst_oam_addr", OAM_ADDR, 32'h0000FE00);
        chk("rst_rd_y", rd_y, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // empty OAM, full address sequence
        start_scan(8'd0, 1'b0, 1'b0);
        chk("busy_first_cycle", busy, 1);
        wait_done(1'b1, 1'b0);
        check_result();

        // single sprite at entry 5, line and height variations
        oam[20] = 8'd16; oam[21] = 8'd40;
        start_scan(8'd0, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
        rd_idx = '0; #1;
        chk("e5_off_const", rd_offset, 8'd20);
        check_result();
        start_scan(8'd8, 1'b0, 1'b0); wait_done(1'b0, 1'b0); check_result();
        start_scan(8'd8, 1'b1, 1'b0); wait_done(1'b0, 1'b0); check_result();

        // twelve hits: buffer fills, overflow sets
        clear_oam();
        for (int e = 0; e < 12; e++) begin
            oam[4*e]   = 8'd16;
            oam[4*e+1] = 8'(e + 1);
        end
        start_scan(8'd3, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
        chk("ovf_count_const", count, 10);
        chk("ovf_flag_const", overflow, 1);
        rd_idx = 4'd9; #1;
        chk("slot9_off_const", rd_offset, 8'd36);
        chk("slot9_x_const", rd_x, 8'd10);
        check_result();
        clear_oam();
        start_scan(8'd3, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
        rd_idx = 4'd9; #1;
        chk("slot9_after_empty", rd_offset, 8'd0);
        check_result();

        // vertical boundaries, no 8-bit wrap
        oam[0] = 8'd159; oam[1] = 8'd1;
        oam[4] = 8'd160; oam[5] = 8'd2;
        oam[8] = 8'd255; oam[9] = 8'd3;
        start_scan(8'd143, 1'b0, 1'b0); wait_done(1'b0, 1'b0); check_result();
        clear_oam();
        oam[0]  = 8'd0;  oam[1]  = 8'd4;
        oam[12] = 8'd1;  oam[13] = 8'd5;
        oam[20] = 8'd17; oam[21] = 8'd6;
        start_scan(8'd0, 1'b1, 1'b0); wait_done(1'b0, 1'b0); check_result();

        // reset in the middle of a scan
        clear_oam();
        for (int e = 0; e < 12; e++) begin
            oam[4*e]   = 8'd16;
            oam[4*e+1] = 8'(e + 1);
        end
        LY = 8'd3; tall = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_count", count, 0);
        chk("abort_overflow", overflow, 0);
        chk("abort_oam_rd", OAM_RD, 0);
        chk("abort_oam_addr", OAM_ADDR, 32'h0000FE00);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        start_scan(8'd3, 1'b0, 1'b0); wait_done(1'b1, 1'b0); check_result();

        // start held high for the whole scan
        start_scan(8'd3, 1'b0, 1'b1); wait_done(1'b0, 1'b1); check_result();

        // back-to-back: read in the DONE cycle, restart from DONE
        clear_oam();
        oam[20] = 8'd16; oam[21] = 8'd40;
        start_scan(8'd0, 1'b0, 1'b0); wait_done(1'b0, 1'b0);
        rd_idx = '0; #1;
        chk("b2b_done_count", count, exp_q[0].cnt);
        chk("b2b_done_x", rd_x, exp_q[0].slots[15:8]);
        chk("b2b_done_off", rd_offset, exp_q[0].slots[7:0]);
        void'(exp_q.pop_front());
        exp_q.push_back(model(8'd8, 1'b1));
        LY = 8'd8; tall = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_addr", OAM_ADDR, 32'h0000FE00);
        chk("b2b_done_low", done, 0);
        wait_done(1'b1, 1'b0);
        check_result();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ppu_oam_scan.md
# ppu_oam_scan

Parametrised OAM scan engine for the PPU's mode-2 phase. On a `start` pulse it walks every OAM entry at a fixed two cycles per entry and selects the sprites whose vertical extent covers the current line. It keeps the first `MAX_SPRITES` matches in a local buffer and reports overflow. The buffer is read back by the pixel-fetch stage through a random-access port.

## Interface
- `NUM_ENTRIES`, default 40: number of OAM entries scanned; 4·NUM_ENTRIES ≤ 256.
- `MAX_SPRITES`, default 10: sprite buffer depth, ≥ 1.
- `OAM_BASE`, default 16'hFE00: byte address of entry 0.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a scan; accepted only when `busy`=0.
- `LY` in 8: current line, latched on accepted start.
- `tall` in 1: sprite height 16 (1) or 8 (0), i.e. LCDC[2]; latched on accepted start.
- `OAM_RD` out 1: OAM read strobe.
- `OAM_ADDR` out 16: OAM byte address.
- `OAM_DATA_in` in 8: read data, valid exactly 1 cycle after the address/strobe cycle.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at scan completion.
- `count` out $clog2(MAX_SPRITES+1): number of sprites stored.
- `overflow` out 1: more than MAX_SPRITES entries matched this line.
- `rd_idx` in $clog2(MAX_SPRITES) (min 1): buffer read index.
- `rd_y`, `rd_x` out 8 each: Y and X bytes of slot `rd_idx`.
- `rd_offset` out 8: OAM byte offset (4·entry) of slot `rd_idx`.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN on `start`=1 with `busy`=0. At that edge: clear `count` and `overflow`, latch `LY` and `tall`, clear the step counter k.
- SCAN covers steps k = 0 … 2·NUM_ENTRIES−1.
  - `OAM_RD`=1 and `OAM_ADDR` = OAM_BASE + 4·(k>>1) + (k&1).
  - Even k addresses the Y byte; odd k addresses the X byte.
- Y evaluation, in the cycle after an even step:
  - hit = (LY+16 ≥ Y) && (LY+16 < Y + (tall ? 16 : 8)).
  - All operands are zero-extended to 9 bits, so there is no 8-bit wrap.
  - Hold Y, hit and the entry index.
- X capture, in the cycle after an odd step:
  - If hit and count < MAX_SPRITES: write {Y, X, 4·entry} to slot `count`, then count+1.
  - If hit and count == MAX_SPRITES: set `overflow` (sticky until the next start) and write nothing.
- After the last X capture the FSM enters DONE for one cycle: `done`=1, `busy`=0. It then returns to IDLE.
- Sprites are stored in OAM order; the lowest entry index takes the lowest slot.
- Read port is combinational:
  - For rd_idx < count: outputs the slot contents.
  - For rd_idx ≥ count, or rd_idx ≥ MAX_SPRITES: outputs 8'h00.
- Buffer contents and `count` stay stable from `done` until the next accepted start.
- `start` while `busy`=1 is ignored and has no side effects.
- `start` in the DONE cycle is accepted, giving a back-to-back scan.
- When not in SCAN: `OAM_RD`=0 and `OAM_ADDR`=OAM_BASE.

## Timing
- Reset (asynchronous, immediate):
  - `busy`=0, `done`=0, `count`=0, `overflow`=0, `OAM_RD`=0, `OAM_ADDR`=OAM_BASE.
  - State = IDLE; rd outputs read 0 because count=0.
  - Reset mid-scan aborts the scan with no `done` pulse.
- Start accepted at edge E0: step k is driven in cycle E0+k, for cycles E0 … E0+2N−1 (N = NUM_ENTRIES).
- Data for step k is sampled at edge E0+k+1.
- The final X capture is at edge E0+2N, which is also the edge that enters DONE. `done`=1 is visible in cycle E0+2N.
- Total scan: 2N+1 cycles including the DONE cycle (81 for N=40).
- `count` and `overflow` update one edge after the corresponding data sample. Both are final when `done`=1.
- Read-port latency is 0 cycles.

## Test plan
- Empty OAM (all Y=0), LY=0, tall=0, start:
  - `OAM_ADDR` sequence FE00, FE01, FE04, FE05, …, FE9D.
  - `done` 80 cycles after start; count=0, overflow=0; rd_idx=0 gives y=x=offset=0.
- Entry 5 with Y=16, X=40:
  - LY=0, tall=0: count=1; slot0 gives y=16, x=40, offset=20.
  - Rescan with LY=8, tall=0: count=0.
  - Rescan with LY=8, tall=1: count=1.
- Entries 0–11 with Y=16, X=entry+1, LY=3:
  - count=10, overflow=1.
  - Slot 9 gives offset=36, x=10; rd_idx=9 then the next scan with no hits returns 0.
- Boundaries, LY=143:
  - Y=159 hits; Y=160 misses; Y=255 misses (no wrap).
  - LY=0, tall=1: Y=1 hits, Y=0 misses, Y=17 misses.
- Reset asserted in cycle 30 of a scan:
  - All outputs return to reset values immediately, with no `done`.
  - A subsequent start with identical OAM yields the full, correct result.
- Handshake:
  - `start` held high throughout the scan: no restart, `done` at cycle 80.
  - `start` during the DONE cycle: a new scan begins next cycle (`busy`=1, OAM_ADDR=FE00); the earlier result was readable in the DONE cycle.
